// File: rtl/game_ctrl_n_if.sv
// Button/switch inputs and display outputs of the swap-puzzle controller, bundled as one port.
// Optional undo button appears when GC_UNDO_EN is defined.
interface game_ctrl_n_if #(
  parameter int N_TILES = 4,
  parameter int TILE_W  = 3,
  parameter int STEP_W  = 8,
  parameter int TIME_W  = 8
);
  logic                        start_sw;
  logic                        set_bt;
  logic                        random_sw;
  logic [N_TILES*TILE_W-1:0]   board_in;
  logic [N_TILES-1:0]          act_bt;
`ifdef GC_UNDO_EN
  logic                        undo_bt;
`endif
  logic [1:0]                  game_status;
  logic [N_TILES*TILE_W-1:0]   board;
  logic                        win_flag;
  logic [STEP_W-1:0]           step_number;
  logic [TIME_W-1:0]           game_time;

`ifdef GC_UNDO_EN
  modport master (
    output start_sw, set_bt, random_sw, board_in, act_bt, undo_bt,
    input  game_status, board, win_flag, step_number, game_time
  );
  modport slave (
    input  start_sw, set_bt, random_sw, board_in, act_bt, undo_bt,
    output game_status, board, win_flag, step_number, game_time
  );
`else
  modport master (
    output start_sw, set_bt, random_sw, board_in, act_bt,
    input  game_status, board, win_flag, step_number, game_time
  );
  modport slave (
    input  start_sw, set_bt, random_sw, board_in, act_bt,
    output game_status, board, win_flag, step_number, game_time
  );
`endif
endinterface

// File: rtl/game_ctrl_n.sv
// N-tile swap-puzzle controller: board register, game FSM, step counter and play timer.
// Tile 0 sits in the most significant field of board/board_in. `define GC_UNDO_EN adds one-level undo.
module game_ctrl_n #(
  parameter int N_TILES  = 4,
  parameter int TILE_W   = 3,
  parameter int STEP_W   = 8,
  parameter int TIME_W   = 8,
  parameter int TICK_DIV = 1000,
  parameter int SCRAMBLE = 16
) (
  input  logic         clk_d,
  input  logic         rst,
  game_ctrl_n_if.slave gif
);
  localparam int BW    = N_TILES * TILE_W;
  localparam int IDX_W = $clog2(N_TILES);
  localparam int PRE_W = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    CHOSE_BOARD  = 2'b00,
    GAMING       = 2'b01,
    GAME_INITIAL = 2'b10,
    WINNED       = 2'b11
  } state_t;

  function automatic logic [BW-1:0] solved_pattern();
    logic [BW-1:0] p;
    p = '0;
    for (int k = 0; k < N_TILES; k++) p[(N_TILES-1-k)*TILE_W +: TILE_W] = TILE_W'(k);
    return p;
  endfunction

  function automatic logic [BW-1:0] swap_tiles(input logic [BW-1:0] b, input int i);
    logic [BW-1:0] r;
    int            j;
    j = (i + 1 == N_TILES) ? 0 : i + 1;
    r = b;
    r[(N_TILES-1-i)*TILE_W +: TILE_W] = b[(N_TILES-1-j)*TILE_W +: TILE_W];
    r[(N_TILES-1-j)*TILE_W +: TILE_W] = b[(N_TILES-1-i)*TILE_W +: TILE_W];
    return r;
  endfunction

  state_t             state_reg;
  logic [BW-1:0]      board_reg;
  logic [STEP_W-1:0]  step_reg;
  logic [TIME_W-1:0]  time_reg;
  logic [PRE_W-1:0]   pre_reg;
  logic               win_reg;
  logic [15:0]        lfsr_reg;
  logic [7:0]         scr_cnt_reg;
  logic               set_prev_reg;
  logic [N_TILES-1:0] act_prev_reg;

  logic               set_press;
  logic [N_TILES-1:0] act_press;
  logic [N_TILES-1:0] tile_ok;
  logic               solved;
  logic               act_any;
  int                 act_idx;
  int                 scr_idx;
  logic [IDX_W-1:0]   scr_raw;
  logic [15:0]        lfsr_next;
  logic [BW-1:0]      act_board;
  logic [BW-1:0]      scr_board;

  assign set_press = gif.set_bt & ~set_prev_reg;
  assign act_press = gif.act_bt & ~act_prev_reg;

  for (genvar gi = 0; gi < N_TILES; gi++) begin : g_tile
    assign tile_ok[gi] = (board_reg[(N_TILES-1-gi)*TILE_W +: TILE_W] == TILE_W'(gi));
  end
  assign solved = &tile_ok;

  // Only the lowest-index new press is honoured.
  always_comb begin
    act_any = 1'b0;
    act_idx = 0;
    for (int i = N_TILES - 1; i >= 0; i--) begin
      if (act_press[i]) begin
        act_any = 1'b1;
        act_idx = i;
      end
    end
  end

  assign lfsr_next = lfsr_reg[0] ? ((lfsr_reg >> 1) ^ 16'hB400) : (lfsr_reg >> 1);
  assign scr_raw   = lfsr_reg[IDX_W-1:0];
  assign scr_idx   = (int'(scr_raw) >= N_TILES) ? int'(scr_raw) - N_TILES : int'(scr_raw);
  assign act_board = swap_tiles(board_reg, act_idx);
  assign scr_board = swap_tiles(board_reg, scr_idx);

`ifdef GC_UNDO_EN
  logic          undo_prev_reg;
  logic [BW-1:0] hist_reg;
  logic          hist_valid_reg;
  logic          undo_press;
  assign undo_press = gif.undo_bt & ~undo_prev_reg;
`endif

  always_ff @(posedge clk_d) begin
    if (rst) begin
      state_reg    <= CHOSE_BOARD;
      board_reg    <= solved_pattern();
      step_reg     <= '0;
      time_reg     <= '0;
      pre_reg      <= '0;
      win_reg      <= 1'b0;
      lfsr_reg     <= 16'hACE1;
      scr_cnt_reg  <= '0;
      set_prev_reg <= 1'b1;
      act_prev_reg <= '1;
`ifdef GC_UNDO_EN
      undo_prev_reg  <= 1'b1;
      hist_reg       <= '0;
      hist_valid_reg <= 1'b0;
`endif
    end else begin
      lfsr_reg     <= lfsr_next;
      set_prev_reg <= gif.set_bt;
      act_prev_reg <= gif.act_bt;
`ifdef GC_UNDO_EN
      undo_prev_reg <= gif.undo_bt;
`endif
      case (state_reg)
        CHOSE_BOARD: begin
          if (set_press) begin
            if (gif.random_sw) begin
              scr_cnt_reg <= 8'(SCRAMBLE);
              state_reg   <= GAME_INITIAL;
            end else begin
              board_reg <= gif.board_in;
            end
          end else if (gif.start_sw && !solved) begin
            state_reg <= GAMING;
            step_reg  <= '0;
            time_reg  <= '0;
            pre_reg   <= '0;
`ifdef GC_UNDO_EN
            hist_valid_reg <= 1'b0;
`endif
          end
        end
        GAME_INITIAL: begin
          board_reg   <= scr_board;
          scr_cnt_reg <= scr_cnt_reg - 8'd1;
          if (scr_cnt_reg == 8'd1) state_reg <= CHOSE_BOARD;
        end
        GAMING: begin
          // A solved board ends the game before any further move or exit is considered.
          if (solved) begin
            state_reg <= WINNED;
            win_reg   <= 1'b1;
          end else if (!gif.start_sw) begin
            state_reg <= CHOSE_BOARD;
          end else begin
            if (pre_reg == PRE_W'(TICK_DIV - 1)) begin
              pre_reg <= '0;
              if (time_reg != '1) time_reg <= time_reg + TIME_W'(1);
            end else begin
              pre_reg <= pre_reg + PRE_W'(1);
            end
            if (act_any) begin
              board_reg <= act_board;
              if (step_reg != '1) step_reg <= step_reg + STEP_W'(1);
`ifdef GC_UNDO_EN
              hist_reg       <= board_reg;
              hist_valid_reg <= 1'b1;
            end else if (undo_press && hist_valid_reg) begin
              board_reg      <= hist_reg;
              hist_valid_reg <= 1'b0;
              if (step_reg != '0) step_reg <= step_reg - STEP_W'(1);
`endif
            end
          end
        end
        WINNED: begin
          if (!gif.start_sw) begin
            state_reg <= CHOSE_BOARD;
            win_reg   <= 1'b0;
          end
        end
        default: state_reg <= CHOSE_BOARD;
      endcase
    end
  end

  assign gif.game_status = state_reg;
  assign gif.board       = board_reg;
  assign gif.win_flag    = win_reg;
  assign gif.step_number = step_reg;
  assign gif.game_time   = time_reg;
endmodule

// File: tb/tb_game_ctrl_n.sv
// Bench for game_ctrl_n: directed vector tables, a scramble sequence, optional undo sequence,
// then randomized play checked against a tile-array reference model.
module tb_game_ctrl_n;
  localparam int N   = 4;
  localparam int TW  = 3;
  localparam int SW  = 2;
  localparam int TMW = 8;
  localparam int TD  = 4;
  localparam int SCR = 16;
  localparam int BW  = N * TW;

  logic clk_d = 1'b0;
  logic rst;
  always #5 clk_d = ~clk_d;

  game_ctrl_n_if #(.N_TILES(N), .TILE_W(TW), .STEP_W(SW), .TIME_W(TMW)) gif ();

  game_ctrl_n #(.N_TILES(N), .TILE_W(TW), .STEP_W(SW), .TIME_W(TMW),
                .TICK_DIV(TD), .SCRAMBLE(SCR)) dut (
    .clk_d(clk_d),
    .rst  (rst),
    .gif  (gif)
  );

  typedef struct {
    bit          set;
    bit          rnd;
    bit          start;
    logic [3:0]  act;
    logic [11:0] bin;
    logic [1:0]  st;
    logic [11:0] brd;
    int          step;
    int          tm;
    bit          win;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: tiles as an int array, game length in ticking cycles.
  int         m_state;
  int         m_tile[N];
  int         m_step;
  int         m_gcyc;
  int         m_scr;
  logic [15:0] m_lfsr;
  bit         m_set_prev;
  bit [N-1:0] m_act_prev;
`ifdef GC_UNDO_EN
  int         m_hist[N];
  bit         m_hv;
  bit         m_undo_prev;
`endif

  function automatic bit m_solved();
    for (int k = 0; k < N; k++) if (m_tile[k] != k) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [BW-1:0] m_board();
    logic [BW-1:0] b;
    b = '0;
    for (int k = 0; k < N; k++) b[(N-1-k)*TW +: TW] = TW'(m_tile[k]);
    return b;
  endfunction

  task automatic m_swap(input int i);
    int t;
    t = m_tile[i];
    m_tile[i] = m_tile[(i+1)%N];
    m_tile[(i+1)%N] = t;
  endtask

  task automatic model_reset();
    m_state = 0;
    for (int k = 0; k < N; k++) m_tile[k] = k;
    m_step = 0; m_gcyc = 0; m_scr = 0;
    m_lfsr = 16'hACE1;
    m_set_prev = 1'b1;
    m_act_prev = '1;
`ifdef GC_UNDO_EN
    m_hv = 1'b0;
    m_undo_prev = 1'b1;
`endif
  endtask

  task automatic model_step();
    bit         set_p;
    bit [N-1:0] act_p;
    int         j;
    int         lo;
`ifdef GC_UNDO_EN
    bit         undo_p;
    undo_p = gif.undo_bt & ~m_undo_prev;
`endif
    set_p = gif.set_bt & ~m_set_prev;
    act_p = gif.act_bt & ~m_act_prev;
    case (m_state)
      0: begin
        if (set_p) begin
          if (gif.random_sw) begin m_scr = SCR; m_state = 2; end
          else for (int k = 0; k < N; k++) m_tile[k] = int'(gif.board_in[(N-1-k)*TW +: TW]);
        end else if (gif.start_sw && !m_solved()) begin
          m_state = 1; m_step = 0; m_gcyc = 0;
`ifdef GC_UNDO_EN
          m_hv = 1'b0;
`endif
        end
      end
      2: begin
        j = int'(m_lfsr) % (1 << $clog2(N));
        if (j >= N) j -= N;
        m_swap(j);
        m_scr--;
        if (m_scr == 0) m_state = 0;
      end
      1: begin
        if (m_solved()) m_state = 3;
        else if (!gif.start_sw) m_state = 0;
        else begin
          m_gcyc++;
          lo = -1;
          for (int k = N - 1; k >= 0; k--) if (act_p[k]) lo = k;
          if (lo >= 0) begin
`ifdef GC_UNDO_EN
            m_hist = m_tile;
            m_hv = 1'b1;
`endif
            m_swap(lo);
            if (m_step < (1 << SW) - 1) m_step++;
          end
`ifdef GC_UNDO_EN
          else if (undo_p && m_hv) begin
            m_tile = m_hist;
            m_hv = 1'b0;
            if (m_step > 0) m_step--;
          end
`endif
        end
      end
      default: if (!gif.start_sw) m_state = 0;
    endcase
    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    m_set_prev = gif.set_bt;
    m_act_prev = gif.act_bt;
`ifdef GC_UNDO_EN
    m_undo_prev = gif.undo_bt;
`endif
  endtask

  task automatic tick();
    if (rst) model_reset();
    else model_step();
    @(posedge clk_d);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    int et;
    et = m_gcyc / TD;
    if (et > (1 << TMW) - 1) et = (1 << TMW) - 1;
    check({tag, " status"}, 64'(gif.game_status), 64'(m_state));
    check({tag, " board"},  64'(gif.board),       64'(m_board()));
    check({tag, " step"},   64'(gif.step_number), 64'(m_step));
    check({tag, " time"},   64'(gif.game_time),   64'(et));
    check({tag, " win"},    64'(gif.win_flag),    64'(m_state == 3));
  endtask

  task automatic run_row(input string tag, input int r, input vec_t v);
    gif.set_bt = v.set; gif.random_sw = v.rnd; gif.start_sw = v.start;
    gif.act_bt = v.act; gif.board_in = v.bin;
    tick();
    check({tag, " status"}, 64'(gif.game_status), 64'(v.st));
    check({tag, " board"},  64'(gif.board),       64'(v.brd));
    check({tag, " step"},   64'(gif.step_number), 64'(v.step));
    check({tag, " time"},   64'(gif.game_time),   64'(v.tm));
    check({tag, " win"},    64'(gif.win_flag),    64'(v.win));
    $display("%s[%0d] set=%0b rnd=%0b start=%0b act=%b -> status=%0d board=%o step=%0d time=%0d win=%0b",
             tag, r, v.set, v.rnd, v.start, v.act, gif.game_status, gif.board,
             gif.step_number, gif.game_time, gif.win_flag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t ta[10];
    vec_t tb[11];
    int   cnt;
    int   v;
    bit [N-1:0] mask;
    bit   pressed;
    int   nt[N];
    int   p;

    //            set rnd st  act      bin      st    brd      stp tm win
    ta[0] = '{0, 0, 0, 4'b0000, 12'o1023, 2'd0, 12'o0123, 0, 0, 0};
    ta[1] = '{1, 0, 0, 4'b0000, 12'o1023, 2'd0, 12'o1023, 0, 0, 0};
    ta[2] = '{0, 0, 1, 4'b0000, 12'o1023, 2'd1, 12'o1023, 0, 0, 0};
    ta[3] = '{0, 0, 1, 4'b0001, 12'o1023, 2'd1, 12'o0123, 1, 0, 0};
    ta[4] = '{0, 0, 1, 4'b0001, 12'o1023, 2'd3, 12'o0123, 1, 0, 1};
    ta[5] = '{0, 0, 1, 4'b0000, 12'o1023, 2'd3, 12'o0123, 1, 0, 1};
    ta[6] = '{0, 0, 1, 4'b0010, 12'o1023, 2'd3, 12'o0123, 1, 0, 1};
    ta[7] = '{0, 0, 0, 4'b0000, 12'o1023, 2'd0, 12'o0123, 1, 0, 0};
    ta[8] = '{0, 0, 1, 4'b0000, 12'o1023, 2'd0, 12'o0123, 1, 0, 0};
    ta[9] = '{1, 1, 0, 4'b0000, 12'o1023, 2'd2, 12'o0123, 1, 0, 0};

    tb[0]  = '{1, 0, 0, 4'b0000, 12'o1023, 2'd0, 12'o1023, 1, 0, 0};
    tb[1]  = '{0, 0, 1, 4'b0000, 12'o1023, 2'd1, 12'o1023, 0, 0, 0};
    tb[2]  = '{0, 0, 1, 4'b1010, 12'o1023, 2'd1, 12'o1203, 1, 0, 0};
    tb[3]  = '{0, 0, 1, 4'b0000, 12'o1023, 2'd1, 12'o1203, 1, 0, 0};
    tb[4]  = '{0, 0, 1, 4'b0100, 12'o1023, 2'd1, 12'o1230, 2, 0, 0};
    tb[5]  = '{0, 0, 1, 4'b0000, 12'o1023, 2'd1, 12'o1230, 2, 1, 0};
    tb[6]  = '{0, 0, 1, 4'b1000, 12'o1023, 2'd1, 12'o0231, 3, 1, 0};
    tb[7]  = '{0, 0, 1, 4'b0000, 12'o1023, 2'd1, 12'o0231, 3, 1, 0};
    tb[8]  = '{0, 0, 1, 4'b0001, 12'o1023, 2'd1, 12'o2031, 3, 1, 0};
    tb[9]  = '{0, 0, 1, 4'b0000, 12'o1023, 2'd1, 12'o2031, 3, 2, 0};
    tb[10] = '{0, 0, 0, 4'b0000, 12'o1023, 2'd0, 12'o2031, 3, 2, 0};

    // Reset with set and act held high: neither may register as a press afterwards.
    rst = 1'b1;
    gif.set_bt = 1'b1; gif.random_sw = 1'b0; gif.start_sw = 1'b0;
    gif.act_bt = 4'b0001; gif.board_in = 12'o1023;
`ifdef GC_UNDO_EN
    gif.undo_bt = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("reset status", 64'(gif.game_status), 64'(0));
    check("reset board",  64'(gif.board),       64'(12'o0123));
    check("reset step",   64'(gif.step_number), 64'(0));
    check("reset time",   64'(gif.game_time),   64'(0));
    check("reset win",    64'(gif.win_flag),    64'(0));
    $display("reset: status=%0d board=%o step=%0d time=%0d", gif.game_status, gif.board,
             gif.step_number, gif.game_time);

    for (int r = 0; r < 10; r++) run_row("tableA", r, ta[r]);

    // Scramble: ta[9] entered GAME_INITIAL; count the cycles it stays there.
    gif.set_bt = 1'b0; gif.random_sw = 1'b0;
    cnt = 1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (gif.game_status == 2'd2) cnt++;
      else break;
    end
    check("scramble cycles", 64'(cnt), 64'(SCR));
    check("scramble status", 64'(gif.game_status), 64'(0));
    mask = '0;
    for (int k = 0; k < N; k++) begin
      v = int'(gif.board[(N-1-k)*TW +: TW]);
      if (v < N) mask[v] = 1'b1;
    end
    check("scramble perm", 64'(mask), 64'({N{1'b1}}));
    check("scramble board", 64'(gif.board), 64'(m_board()));
    $display("scramble: %0d cycles, board=%o", cnt, gif.board);

    for (int r = 0; r < 11; r++) run_row("tableB", r, tb[r]);

`ifdef GC_UNDO_EN
    gif.set_bt = 1'b1; gif.board_in = 12'o1203; tick();
    gif.set_bt = 1'b0; gif.start_sw = 1'b1; tick();
    gif.act_bt = 4'b0001; tick();
    gif.act_bt = 4'b0000; tick();
    gif.act_bt = 4'b0010; tick();
    check("undo pre board", 64'(gif.board), 64'(12'o2013));
    gif.act_bt = 4'b0000; tick();
    gif.undo_bt = 1'b1; tick();
    check("undo board", 64'(gif.board),       64'(12'o2103));
    check("undo step",  64'(gif.step_number), 64'(1));
    gif.undo_bt = 1'b0; tick();
    gif.undo_bt = 1'b1; tick();
    check("undo2 board", 64'(gif.board),       64'(12'o2103));
    check("undo2 step",  64'(gif.step_number), 64'(1));
    $display("undo: board=%o step=%0d", gif.board, gif.step_number);
    gif.undo_bt = 1'b0; gif.start_sw = 1'b0; tick();
`endif

    check_model("model sync");

    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 49) == 0) gif.start_sw = ~gif.start_sw;
      gif.set_bt    = ($urandom_range(0, 29) == 0);
      gif.random_sw = 1'($urandom_range(0, 1));
      for (int k = 0; k < N; k++) gif.act_bt[k] = ($urandom_range(0, 7) == 0);
`ifdef GC_UNDO_EN
      gif.undo_bt = ($urandom_range(0, 5) == 0);
`endif
      if ($urandom_range(0, 1) == 0) begin
        for (int k = 0; k < N; k++) nt[k] = k;
        p = $urandom_range(0, N - 1);
        v = nt[p]; nt[p] = nt[(p+1)%N]; nt[(p+1)%N] = v;
        for (int k = 0; k < N; k++) gif.board_in[(N-1-k)*TW +: TW] = TW'(nt[k]);
      end else begin
        gif.board_in = BW'($urandom);
      end
      pressed = rst || (gif.set_bt && !m_set_prev) || (|(gif.act_bt & ~m_act_prev));
      tick();
      check_model("random");
      if (pressed)
        $display("rand[%0d] rst=%0b set=%0b rnd=%0b start=%0b act=%b -> status=%0d board=%o step=%0d time=%0d",
                 c, rst, gif.set_bt, gif.random_sw, gif.start_sw, gif.act_bt,
                 gif.game_status, gif.board, gif.step_number, gif.game_time);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
